// File: rtl/hpdmc_wrser16.sv
// hpdmc_wrser16: 64-bit write burst to 16-bit DDR half-word serializer.
// Drives d0/d1 with byte masks plus DQ and DQS output-enable windows.
module hpdmc_wrser16 #(
    parameter int BURST = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        wr_start,
    input  logic [63:0] wd_i,
    input  logic [7:0]  wsel_i,
    output logic        wd_ack,
    output logic [15:0] d0,
    output logic [15:0] d1,
    output logic [1:0]  dm0,
    output logic [1:0]  dm1,
    output logic        dq_oe,
    output logic        dqs_oe,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        POST
    } state_t;

    localparam logic [3:0] LAST = 4'(2 * BURST - 1);

    state_t      state;
    logic [3:0]  b;
    logic [63:0] h;
    logic [7:0]  hsel;

    // A word is taken in PRE and on every odd beat except the final one.
    assign wd_ack = (state == PRE) ||
                    ((state == DATA) && b[0] && (b != LAST));

    // Sequencer: outputs are loaded for the cycle being entered, so the
    // upper half of a new word goes straight from wd_i to d0/d1.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state  <= IDLE;
            b      <= 4'd0;
            h      <= 64'd0;
            hsel   <= 8'd0;
            d0     <= 16'd0;
            d1     <= 16'd0;
            dm0    <= 2'b11;
            dm1    <= 2'b11;
            dq_oe  <= 1'b0;
            dqs_oe <= 1'b0;
            busy   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (wr_start) begin
                        state  <= PRE;
                        dqs_oe <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                PRE: begin
                    state <= DATA;
                    b     <= 4'd0;
                    h     <= wd_i;
                    hsel  <= wsel_i;
                    d0    <= wd_i[63:48];
                    d1    <= wd_i[47:32];
                    dm0   <= ~wsel_i[7:6];
                    dm1   <= ~wsel_i[5:4];
                    dq_oe <= 1'b1;
                end
                DATA: begin
                    if (b == LAST) begin
                        state <= POST;
                        b     <= 4'd0;
                        d0    <= 16'd0;
                        d1    <= 16'd0;
                        dm0   <= 2'b11;
                        dm1   <= 2'b11;
                        dq_oe <= 1'b0;
                    end else begin
                        b <= b + 4'd1;
                        if (b[0]) begin
                            h    <= wd_i;
                            hsel <= wsel_i;
                            d0   <= wd_i[63:48];
                            d1   <= wd_i[47:32];
                            dm0  <= ~wsel_i[7:6];
                            dm1  <= ~wsel_i[5:4];
                        end else begin
                            d0  <= h[31:16];
                            d1  <= h[15:0];
                            dm0 <= ~hsel[3:2];
                            dm1 <= ~hsel[1:0];
                        end
                    end
                end
                POST: begin
                    state  <= IDLE;
                    dqs_oe <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
